// File: rtl/grasspopper_pkg.sv
// -----------------------------------------------------------------------------
// grasspopper_pkg
// Shared constants and the FSM state type for the Kuznyechik (GOST R 34.12-2015)
// iterative round sequencer. Imported by grasspopper_ctrl.
//   BLOCK_W    : cipher block width in bits (16 bytes)
//   ROUNDS     : number of rounds driven through the shared round unit
//   LAST_ROUND : index of the final key-xor-only round
//   state_e    : sequencer FSM states
// -----------------------------------------------------------------------------
package grasspopper_pkg;

    localparam int         BLOCK_W    = 128;
    localparam int         ROUNDS     = 10;
    localparam logic [3:0] LAST_ROUND = 4'(ROUNDS - 1);

    // IDLE : waiting for a plaintext block
    // ISSUE: one-cycle launch of the current round
    // WAIT : waiting for the round unit result (watchdog running)
    // OUT  : presenting the ciphertext until the consumer takes it
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        OUT
    } state_e;

endpackage

// File: rtl/grasspopper_ctrl.sv
// -----------------------------------------------------------------------------
// grasspopper_ctrl
// Iterative round sequencer for the Kuznyechik encoder. Accepts one block,
// drives a single external round unit through rounds 0..9 (0..8 full X-S-L,
// 9 key-xor only) and returns the ciphertext.
//
// Ports
//   clk, reset        : clock, synchronous active-high reset
//   in_valid/in_ready : plaintext handshake, in_data carries the block
//   out_valid/out_ready: ciphertext handshake, out_data carries the block
//   busy              : a block is in flight
//   err_o             : one-cycle pulse when the round unit timed out
//   rnd_start_o       : one-cycle pulse launching a round
//   rnd_num_o         : current round index (key select)
//   rnd_last_o        : current round is the key-xor-only round
//   rnd_data_o        : working block fed to the round unit
//   rnd_done_i        : round unit result valid (one-cycle pulse)
//   rnd_data_i        : round unit result
// -----------------------------------------------------------------------------
module grasspopper_ctrl
    import grasspopper_pkg::*;
#(
    parameter int BLOCK_W = grasspopper_pkg::BLOCK_W,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [BLOCK_W-1:0] in_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [BLOCK_W-1:0] out_data,
    output logic               busy,
    output logic               err_o,
    output logic               rnd_start_o,
    output logic [3:0]         rnd_num_o,
    output logic               rnd_last_o,
    output logic [BLOCK_W-1:0] rnd_data_o,
    input  logic               rnd_done_i,
    input  logic [BLOCK_W-1:0] rnd_data_i
);

    // The watchdog only has to count up to TIMEOUT-1: the TIMEOUT-th silent
    // WAIT cycle is detected while the counter still holds TIMEOUT-1.
    localparam int                WDOG_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_MAX = WDOG_W'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);

    state_e              state_q, state_d;
    logic [BLOCK_W-1:0]  st_q, st_d;
    logic [3:0]          rnd_q, rnd_d;
    logic [WDOG_W-1:0]   wdog_q, wdog_d;
    logic                err_q, err_d;

    // State register. err_q is registered so the timeout pulse lands in the
    // first IDLE cycle after the abort.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            st_q    <= '0;
            rnd_q   <= '0;
            wdog_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            st_q    <= st_d;
            rnd_q   <= rnd_d;
            wdog_q  <= wdog_d;
            err_q   <= err_d;
        end
    end

    // Next-state logic. rnd_done_i is only looked at in WAIT, so a stray done
    // in IDLE or in the launch cycle cannot disturb st or rnd. A done arriving
    // in the last allowed WAIT cycle is checked first and beats the watchdog.
    always_comb begin
        state_d = state_q;
        st_d    = st_q;
        rnd_d   = rnd_q;
        wdog_d  = wdog_q;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (in_valid) begin
                    st_d    = in_data;
                    rnd_d   = '0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                wdog_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (rnd_done_i) begin
                    st_d = rnd_data_i;
                    if (rnd_q == LAST_ROUND) begin
                        state_d = OUT;
                    end else begin
                        rnd_d   = rnd_q + 4'd1;
                        state_d = ISSUE;
                    end
                end else if ((TIMEOUT != 0) && (wdog_q == WDOG_MAX)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            OUT: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are plain decodes of registered state, forced to zero while
    // reset is held so nothing downstream sees a handshake during reset.
    assign in_ready    = ~reset & (state_q == IDLE);
    assign out_valid   = ~reset & (state_q == OUT);
    assign busy        = ~reset & (state_q != IDLE);
    assign err_o       = ~reset & err_q;
    assign rnd_start_o = ~reset & (state_q == ISSUE);
    assign rnd_last_o  = ~reset & (rnd_q == LAST_ROUND);
    assign rnd_num_o   = reset ? 4'd0 : rnd_q;
    assign rnd_data_o  = reset ? '0 : st_q;
    assign out_data    = reset ? '0 : st_q;

endmodule

// File: tb/tb_grasspopper_ctrl.sv
// -----------------------------------------------------------------------------
// tb_grasspopper_ctrl
// Self-checking bench for grasspopper_ctrl. A behavioural round unit answers
// each launch after a programmable latency; a reference model applies the ten
// rounds to the plaintext directly and predicts the ciphertext.
// -----------------------------------------------------------------------------
module tb_grasspopper_ctrl;

    localparam int BW     = 128;
    localparam int NROUND = 10;

    logic          clk;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [BW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_data;
    logic          busy;
    logic          err_o;
    logic          rnd_start_o;
    logic [3:0]    rnd_num_o;
    logic          rnd_last_o;
    logic [BW-1:0] rnd_data_o;
    logic          rnd_done_i;
    logic [BW-1:0] rnd_data_i;

    int nCompared   = 0;
    int nMismatched = 0;

    // Round unit model controls
    int            respLat     = 1;
    int            silentRound = -1;
    bit            respEn      = 1'b1;
    bit            echoMode    = 1'b1;
    logic [BW-1:0] keys [NROUND];

    logic          respDone = 1'b0;
    logic [BW-1:0] respData = '0;
    logic          spurDone = 1'b0;
    logic [BW-1:0] spurData = '0;
    bit            pending  = 1'b0;
    int            cnt      = 0;
    logic [BW-1:0] pendData = '0;

    assign rnd_done_i = respDone | spurDone;
    assign rnd_data_i = spurDone ? spurData : respData;

    grasspopper_ctrl #(
        .BLOCK_W (BW),
        .TIMEOUT (8)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .busy        (busy),
        .err_o       (err_o),
        .rnd_start_o (rnd_start_o),
        .rnd_num_o   (rnd_num_o),
        .rnd_last_o  (rnd_last_o),
        .rnd_data_o  (rnd_data_o),
        .rnd_done_i  (rnd_done_i),
        .rnd_data_i  (rnd_data_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One round: echo mode xors the round index in; otherwise rotate left by
    // one bit and xor the round key, so round order matters.
    function automatic logic [BW-1:0] roundFn(input logic [BW-1:0] x, input int r);
        if (echoMode) return x ^ BW'(r);
        return {x[BW-2:0], x[BW-1]} ^ keys[r];
    endfunction

    function automatic logic [BW-1:0] refEncrypt(input logic [BW-1:0] d);
        logic [BW-1:0] x = d;
        for (int r = 0; r < NROUND; r++) x = roundFn(x, r);
        return x;
    endfunction

    function automatic logic [BW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic randomizeKeys();
        for (int k = 0; k < NROUND; k++) keys[k] = rand128();
    endtask

    // Behavioural round unit: launch seen mid-cycle, result driven so that
    // rnd_done_i is sampled exactly respLat cycles after rnd_start_o.
    always @(negedge clk) begin
        respDone = 1'b0;
        if (reset || !respEn) begin
            pending = 1'b0;
        end else begin
            if (pending) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    respDone = 1'b1;
                    respData = pendData;
                    pending  = 1'b0;
                end
            end
            if (rnd_start_o && (int'(rnd_num_o) != silentRound)) begin
                pendData = roundFn(rnd_data_o, int'(rnd_num_o));
                cnt      = respLat;
                pending  = 1'b1;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        nCompared++;
        assert (obs === exp) else begin
            nMismatched++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents a block and returns at the mid-point of the launch cycle.
    task automatic acceptBlock(input logic [BW-1:0] data);
        int guard = 0;
        in_valid = 1'b1;
        in_data  = data;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("accept_in_ready", in_ready, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = rand128();
    endtask

    // Counts cycles (accept cycle = 0) until out_valid, checking every launch.
    task automatic waitOutput(input int cyc0, input int starts0, input int expLat);
        int cyc    = cyc0;
        int starts = starts0;
        while (!out_valid && cyc < 400) begin
            if (rnd_start_o) begin
                checkOutput("rnd_num", rnd_num_o, starts);
                checkOutput("rnd_last", rnd_last_o, (starts == NROUND - 1));
                starts++;
            end
            @(negedge clk);
            cyc++;
        end
        checkOutput("latency", cyc, expLat);
        checkOutput("start_count", starts, NROUND);
    endtask

    task automatic applyStimulus(input logic [BW-1:0] data, input int expLat);
        acceptBlock(data);
        waitOutput(1, 0, expLat);
    endtask

    // Holds out_ready low for 'hold' cycles, then takes the ciphertext.
    task automatic collectOutput(input logic [BW-1:0] exp, input int hold);
        checkOutput("out_valid", out_valid, 1'b1);
        checkOutput("out_data", out_data, exp);
        checkOutput("out_in_ready", in_ready, 1'b0);
        checkOutput("out_busy", busy, 1'b1);
        for (int h = 0; h < hold; h++) begin
            out_ready = 1'b0;
            @(negedge clk);
            checkOutput("hold_out_valid", out_valid, 1'b1);
            checkOutput("hold_out_data", out_data, exp);
            checkOutput("hold_in_ready", in_ready, 1'b0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        checkOutput("post_out_valid", out_valid, 1'b0);
        checkOutput("post_busy", busy, 1'b0);
        checkOutput("post_in_ready", in_ready, 1'b1);
    endtask

    initial begin
        logic [BW-1:0] d1, d2, lastResult;
        int guard;

        reset     = 1'b1;
        in_valid  = 1'b1;
        in_data   = 128'hdeadbeef_deadbeef_deadbeef_deadbeef;
        out_ready = 1'b0;
        randomizeKeys();

        // Reset held three cycles with a block offered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("rst_in_ready", in_ready, 1'b0);
            checkOutput("rst_out_valid", out_valid, 1'b0);
            checkOutput("rst_busy", busy, 1'b0);
            checkOutput("rst_err", err_o, 1'b0);
            checkOutput("rst_start", rnd_start_o, 1'b0);
        end
        reset    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("rel_in_ready", in_ready, 1'b1);
        checkOutput("rel_busy", busy, 1'b0);
        checkOutput("rel_rnd_data", rnd_data_o, '0);
        checkOutput("rel_rnd_num", rnd_num_o, 4'd0);

        // Echo round unit, L=1: result is the plaintext xor 1
        echoMode = 1'b1;
        respLat  = 1;
        d1 = 128'h0123456789abcdef0123456789abcdef;
        applyStimulus(d1, 21);
        collectOutput(d1 ^ 128'h1, 0);

        // Backpressure with a second block waiting
        echoMode = 1'b0;
        randomizeKeys();
        d1 = rand128();
        d2 = rand128();
        applyStimulus(d1, 21);
        in_valid = 1'b1;
        in_data  = d2;
        collectOutput(refEncrypt(d1), 5);
        applyStimulus(d2, 21);
        collectOutput(refEncrypt(d2), 0);

        // Randomized blocks, keys and latencies
        for (int b = 0; b < 4; b++) begin
            randomizeKeys();
            respLat = int'($urandom_range(1, 4));
            d1 = rand128();
            applyStimulus(d1, 10 * (respLat + 1) + 1);
            collectOutput(refEncrypt(d1), int'($urandom_range(0, 3)));
        end

        // Done in the last allowed WAIT cycle still wins over the watchdog
        respLat = 8;
        d1 = rand128();
        applyStimulus(d1, 10 * 9 + 1);
        lastResult = refEncrypt(d1);
        collectOutput(lastResult, 0);

        // Spurious done while idle leaves st and rnd alone
        respLat  = 1;
        spurDone = 1'b1;
        spurData = rand128();
        @(negedge clk);
        spurDone = 1'b0;
        @(negedge clk);
        checkOutput("idle_spur_st", rnd_data_o, lastResult);
        checkOutput("idle_spur_rnd", rnd_num_o, 4'd9);
        checkOutput("idle_spur_busy", busy, 1'b0);

        // Spurious done in the launch cycle is ignored
        d1 = rand128();
        acceptBlock(d1);
        spurDone = 1'b1;
        spurData = ~d1;
        @(negedge clk);
        spurDone = 1'b0;
        checkOutput("issue_spur_st", rnd_data_o, d1);
        checkOutput("issue_spur_rnd", rnd_num_o, 4'd0);
        waitOutput(2, 1, 21);
        collectOutput(refEncrypt(d1), 0);

        // Watchdog: round unit silent on round 3
        silentRound = 3;
        d1 = rand128();
        acceptBlock(d1);
        guard = 0;
        while (!(rnd_start_o && rnd_num_o == 4'd3) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("to_round3_start", rnd_start_o, 1'b1);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checkOutput("to_err", err_o, (k == 9));
            checkOutput("to_out_valid", out_valid, 1'b0);
        end
        checkOutput("to_in_ready", in_ready, 1'b1);
        checkOutput("to_busy", busy, 1'b0);
        @(negedge clk);
        checkOutput("to_err_drop", err_o, 1'b0);
        checkOutput("to_no_out", out_valid, 1'b0);
        silentRound = -1;

        // Reset during round 5 WAIT, then a late done after release
        randomizeKeys();
        respLat = 3;
        d1 = rand128();
        acceptBlock(d1);
        guard = 0;
        while (!(rnd_start_o && rnd_num_o == 4'd5) && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        checkOutput("mr_round5_start", rnd_start_o, 1'b1);
        @(negedge clk);
        respEn = 1'b0;
        reset  = 1'b1;
        @(negedge clk);
        checkOutput("mr_busy", busy, 1'b0);
        checkOutput("mr_in_ready", in_ready, 1'b0);
        checkOutput("mr_err", err_o, 1'b0);
        @(negedge clk);
        reset    = 1'b0;
        spurDone = 1'b1;
        spurData = rand128();
        @(negedge clk);
        spurDone = 1'b0;
        respEn   = 1'b1;
        checkOutput("mr_late_busy", busy, 1'b0);
        checkOutput("mr_late_ready", in_ready, 1'b1);
        checkOutput("mr_late_st", rnd_data_o, '0);
        checkOutput("mr_late_rnd", rnd_num_o, 4'd0);
        checkOutput("mr_late_err", err_o, 1'b0);
        d2 = rand128();
        applyStimulus(d2, 41);
        collectOutput(refEncrypt(d2), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/grasspopper_ctrl.md
# grasspopper_ctrl

Iterative round sequencer for the GOST R 34.12-2015 (Kuznyechik) encoder. It accepts one 128-bit block over a valid/ready handshake and drives a single shared external round unit through rounds 0..9. Rounds 0..8 are full X-S-L rounds; round 9 is the key-xor-only round. It returns the ciphertext over a second valid/ready handshake. The block sits between the host interface and the round/key_xor datapath. It replaces ten unrolled stages with one time-shared unit.

## Interface
- BLOCK_W, 128: block width in bits (16 bytes).
- TIMEOUT, 16: maximum WAIT cycles per round before abort; 0 disables the watchdog.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input block present.
- in_ready  out  1  controller can accept a block.
- in_data  in  BLOCK_W  plaintext block.
- out_valid  out  1  ciphertext present.
- out_ready  in  1  consumer accepts ciphertext.
- out_data  out  BLOCK_W  ciphertext block.
- busy  out  1  block in flight (state != IDLE).
- err_o  out  1  one-cycle pulse, round unit timed out.
- rnd_start_o  out  1  one-cycle pulse, launch round.
- rnd_num_o  out  4  current round index 0..9 (key select).
- rnd_last_o  out  1  current round is 9 (key xor only).
- rnd_data_o  out  BLOCK_W  round unit input (state register).
- rnd_done_i  in  1  round unit result valid (one-cycle pulse).
- rnd_data_i  in  BLOCK_W  round unit result.

## Operation
- State register `st` (BLOCK_W) holds the working block. `rnd` (4 bit) is the round counter. `wdog` counts WAIT cycles.
- FSM states: IDLE, ISSUE, WAIT, OUT.
- IDLE: in_ready=1. If in_valid, then st<=in_data, rnd<=0, next state ISSUE.
- ISSUE: rnd_start_o=1 for this cycle only. wdog<=0. Next state WAIT.
- WAIT: if rnd_done_i, then st<=rnd_data_i. If rnd==9, go to OUT; otherwise rnd<=rnd+1 and go to ISSUE. Each WAIT cycle without done increments wdog.
- Watchdog: only when TIMEOUT!=0. If wdog reaches TIMEOUT (done absent for TIMEOUT WAIT cycles), go to IDLE and drop the block. err_o=1 in the next cycle, which is also the first IDLE cycle.
- Watchdog vs. done: done in the TIMEOUT-th WAIT cycle is accepted and wins over the timeout.
- OUT: out_valid=1, out_data=st. When out_ready is high, go to IDLE. in_ready=0 in OUT; there is no bypass and no overlap.
- rnd_done_i outside WAIT is ignored. This covers done in the same cycle as rnd_start_o.
- rnd_num_o=rnd and rnd_last_o=(rnd==9) in all states. rnd_data_o=st.
- rnd never exceeds 9; there is no wrap-around.

## Timing
- Reset values: st=0, rnd=0, state IDLE. While reset is high, all outputs are 0, including in_ready. in_ready=1 from the first cycle after reset deasserts.
- Reset mid-operation aborts the block with no err_o. A late rnd_done_i after reset is ignored.
- Round unit contract: rnd_done_i arrives L>=1 cycles after rnd_start_o, with rnd_data_i valid in the same cycle.
- Each round takes L+1 cycles.
- out_valid rises 10·(L+1)+1 cycles after the accepting in_valid&in_ready edge. For L=1 that is 21 cycles.
- out_data stays stable while out_valid=1 and out_ready=0.
- busy is registered state decode: 1 from the cycle after accept through the last OUT cycle.

## Structure
- grasspopper_pkg holds:
  - ROUNDS=10 and LAST_ROUND=4'd9;
  - BLOCK_W=128;
  - the FSM state typedef {IDLE, ISSUE, WAIT, OUT}.
- No sub-module is required. The round unit (stage / key_xor wrapper with key table) is instantiated outside, next to this controller.
- A watchdog counter module, ctrl_wdog, is optional.

## Test plan
- Reset: hold reset 3 cycles with in_valid=1. Required: in_ready, out_valid, busy, err_o and rnd_start_o all 0, and no block accepted. After release, in_ready=1.
- Single block, L=1, echo model rnd_data_i = rnd_data_o ^ rnd_num_o, in_data=128'h0123…EF. Required:
  - exactly 10 rnd_start_o pulses;
  - rnd_num_o runs 0..9, with rnd_last_o only at 9;
  - out_valid 21 cycles after accept;
  - out_data = in_data ^ 128'h1.
- Backpressure: out_ready=0 for 5 cycles, with a second in_valid pending. Required: out_valid held, out_data stable, in_ready=0. The second block is accepted only in the first IDLE cycle after the out handshake.
- Timeout: TIMEOUT=8, round unit silent on round 3. Required: err_o high for exactly 1 cycle, 9 cycles after that round's rnd_start_o. Then IDLE with in_ready=1, and no out_valid.
- Reset mid-round: assert reset during round 5 WAIT, then pulse rnd_done_i after release. Required: the late done is ignored, and the next block gives a correct result with full 10-round latency.
- Spurious done: pulse rnd_done_i in IDLE and in the ISSUE cycle. Required: st and rnd unchanged, and the result equals the clean run.
